// File: rtl/mlp_argmax.sv
// -----------------------------------------------------------------------------
// mlp_argmax
//   Takes a snapshot of a batch of MLP output scores and reports the argmax of
//   each sample. Scores are compared as signed 32-bit values, one element per
//   cycle. Each result is handed to the consumer over a valid/ready handshake,
//   and done is raised once the last sample of the batch has been accepted.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   start       in   capture data_in and run (sampled only while idle)
//   data_in     in   [31:0] x [COUNT][OUTPUT_SIZE] signed scores
//   busy        out  high whenever a batch is in progress
//   out_valid   out  result of the current sample is presented
//   out_ready   in   consumer accepts the presented result
//   class_idx   out  index of the winning score (lowest index on ties)
//   max_val     out  winning score
//   sample_idx  out  sample number of the presented result
//   done        out  batch complete; held until the next accepted start
// -----------------------------------------------------------------------------
module mlp_argmax #(
  parameter int OUTPUT_SIZE = 4,
  parameter int COUNT       = 1,
  parameter int IDX_W       = ($clog2(OUTPUT_SIZE) > 0 ? $clog2(OUTPUT_SIZE) : 1),
  parameter int SMP_W       = ($clog2(COUNT) > 0 ? $clog2(COUNT) : 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      data_in [COUNT][OUTPUT_SIZE],
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] class_idx,
  output logic [31:0]      max_val,
  output logic [SMP_W-1:0] sample_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_t;

  // First element examined by SCAN. With a single score per sample there is
  // nothing to scan, so keep the counter at 0 to stay inside the array.
  localparam logic [IDX_W-1:0] K_INIT = (OUTPUT_SIZE > 1) ? IDX_W'(1) : '0;
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(OUTPUT_SIZE - 1);
  localparam logic [SMP_W-1:0] S_LAST = SMP_W'(COUNT - 1);
  localparam state_t AFTER_LOAD = (OUTPUT_SIZE > 1) ? SCAN : EMIT;

  state_t             state_q, state_d;
  logic [SMP_W-1:0]   s_q, s_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [31:0]        best_q, best_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               done_q, done_d;
  logic               load;

  // Snapshot of the batch; contents are only meaningful after a capture, so
  // it carries no reset.
  logic [31:0]        snap_q [COUNT][OUTPUT_SIZE];

  logic [31:0]        cur_elem;
  logic [SMP_W-1:0]   s_inc;

  assign cur_elem = snap_q[s_q][k_q];
  // Wraps at the last sample so the first-element read below never indexes
  // past the end of the snapshot; the wrapped value is never used.
  assign s_inc    = (s_q == S_LAST) ? '0 : s_q + SMP_W'(1);

  always_ff @(posedge clk) begin
    if (load) begin
      snap_q <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      k_q        <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      k_q        <= k_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    k_d        = k_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    done_d     = done_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // The snapshot is written at this same edge, so seed the running
          // maximum straight from the input.
          load       = 1'b1;
          done_d     = 1'b0;
          s_d        = '0;
          best_d     = data_in[0][0];
          best_idx_d = '0;
          k_d        = K_INIT;
          state_d    = AFTER_LOAD;
        end
      end

      SCAN: begin
        // Strict compare: an equal score never displaces an earlier index.
        if ($signed(cur_elem) > $signed(best_q)) begin
          best_d     = cur_elem;
          best_idx_d = k_q;
        end
        if (k_q == K_LAST) begin
          state_d = EMIT;
        end else begin
          k_d = k_q + IDX_W'(1);
        end
      end

      EMIT: begin
        if (out_ready) begin
          if (s_q == S_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d        = s_inc;
            best_d     = snap_q[s_inc][0];
            best_idx_d = '0;
            k_d        = K_INIT;
            state_d    = AFTER_LOAD;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result fields read as zero whenever no result is being presented.
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == EMIT);
  assign class_idx  = out_valid ? best_idx_q : '0;
  assign max_val    = out_valid ? best_q : '0;
  assign sample_idx = out_valid ? s_q : '0;
  assign done       = done_q;

endmodule

// File: tb/tb_mlp_argmax.sv
// -----------------------------------------------------------------------------
// tb_mlp_argmax
//   Two instances: A (4 scores x 2 samples) and C (1 score x 3 samples).
//   A batch-level model predicts busy/out_valid/done and the presented result
//   on every cycle; directed sections pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_mlp_argmax;

  localparam int OS_A  = 4;
  localparam int CNT_A = 2;
  localparam int OS_C  = 1;
  localparam int CNT_C = 3;

  logic clk;
  logic rst;

  logic        start_a, ready_a;
  logic [31:0] data_a [CNT_A][OS_A];
  logic        busy_a, out_valid_a, done_a;
  logic [1:0]  class_idx_a;
  logic [31:0] max_val_a;
  logic [0:0]  sample_idx_a;

  logic        start_c, ready_c;
  logic [31:0] data_c [CNT_C][OS_C];
  logic        busy_c, out_valid_c, done_c;
  logic [0:0]  class_idx_c;
  logic [31:0] max_val_c;
  logic [1:0]  sample_idx_c;

  int checks = 0;
  int errors = 0;

  mlp_argmax #(.OUTPUT_SIZE(OS_A), .COUNT(CNT_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_a),
    .busy(busy_a), .out_valid(out_valid_a), .out_ready(ready_a),
    .class_idx(class_idx_a), .max_val(max_val_a),
    .sample_idx(sample_idx_a), .done(done_a)
  );

  mlp_argmax #(.OUTPUT_SIZE(OS_C), .COUNT(CNT_C)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(data_c),
    .busy(busy_c), .out_valid(out_valid_c), .out_ready(ready_c),
    .class_idx(class_idx_c), .max_val(max_val_c),
    .sample_idx(sample_idx_c), .done(done_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0 = A, 1 = C) ----------------
  // A batch is a list of per-sample argmax results. After capture (or after a
  // handshake that leaves samples pending) the next result shows up OS-1
  // edges later and stays until accepted.
  bit          m_busy  [2];
  bit          m_valid [2];
  bit          m_done  [2];
  int          m_s     [2];
  int          m_wait  [2];
  int          m_idx   [2][3];
  logic [31:0] m_val   [2][3];

  task automatic model_reset(input int n);
    m_busy[n]  = 0;
    m_valid[n] = 0;
    m_done[n]  = 0;
    m_s[n]     = 0;
    m_wait[n]  = 0;
  endtask

  task automatic model_edge(input int n, input int os, input int cnt, input logic st, input logic rdy);
    if (!m_busy[n]) begin
      if (st) begin
        m_busy[n]  = 1;
        m_done[n]  = 0;
        m_s[n]     = 0;
        m_wait[n]  = os - 1;
        m_valid[n] = (os == 1);
      end
    end else if (m_valid[n]) begin
      if (rdy) begin
        if (m_s[n] == cnt - 1) begin
          m_busy[n]  = 0;
          m_valid[n] = 0;
          m_done[n]  = 1;
        end else begin
          m_s[n]     = m_s[n] + 1;
          m_wait[n]  = os - 1;
          m_valid[n] = (os == 1);
        end
      end
    end else begin
      m_wait[n] = m_wait[n] - 1;
      if (m_wait[n] == 0) m_valid[n] = 1;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      if (!m_busy[0] && start_a) begin
        for (int s = 0; s < CNT_A; s++) begin
          int bi;
          logic [31:0] bv;
          bi = 0;
          bv = data_a[s][0];
          for (int k = 1; k < OS_A; k++)
            if ($signed(data_a[s][k]) > $signed(bv)) begin
              bv = data_a[s][k];
              bi = k;
            end
          m_idx[0][s] = bi;
          m_val[0][s] = bv;
        end
      end
      if (!m_busy[1] && start_c) begin
        for (int s = 0; s < CNT_C; s++) begin
          m_idx[1][s] = 0;
          m_val[1][s] = data_c[s][0];
        end
      end
      model_edge(0, OS_A, CNT_A, start_a, ready_a);
      model_edge(1, OS_C, CNT_C, start_c, ready_c);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("a_busy",  32'(busy_a),      32'(m_busy[0]));
      check("a_valid", 32'(out_valid_a), 32'(m_valid[0]));
      check("a_done",  32'(done_a),      32'(m_done[0]));
      if (m_valid[0]) begin
        check("a_idx", 32'(class_idx_a),  32'(m_idx[0][m_s[0]]));
        check("a_val", max_val_a,         m_val[0][m_s[0]]);
        check("a_smp", 32'(sample_idx_a), 32'(m_s[0]));
      end
      check("c_busy",  32'(busy_c),      32'(m_busy[1]));
      check("c_valid", 32'(out_valid_c), 32'(m_valid[1]));
      check("c_done",  32'(done_c),      32'(m_done[1]));
      if (m_valid[1]) begin
        check("c_idx", 32'(class_idx_c),  32'(m_idx[1][m_s[1]]));
        check("c_val", max_val_c,         m_val[1][m_s[1]]);
        check("c_smp", 32'(sample_idx_c), 32'(m_s[1]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_row_a(input int s, input int v0, input int v1, input int v2, input int v3);
    data_a[s][0] = v0;
    data_a[s][1] = v1;
    data_a[s][2] = v2;
    data_a[s][3] = v3;
  endtask

  task automatic rand_data;
    for (int i = 0; i < CNT_A; i++)
      for (int j = 0; j < OS_A; j++) begin
        int v;
        v = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 8)) - 4;
        data_a[i][j] = v;
      end
    for (int i = 0; i < CNT_C; i++) begin
      int v;
      v = int'($urandom_range(0, 8)) - 4;
      data_c[i][0] = v;
    end
  endtask

  // Pulse start for one cycle, then count negedges until out_valid shows.
  task automatic run_start_a(output int lat);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    lat = 1;
    while (!out_valid_a && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // From a cycle where a result is being accepted, count negedges until the
  // next result is presented.
  task automatic next_valid_a(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!out_valid_a && gap < 50);
  endtask

  task automatic expect_a(input string tag, input int idx, input logic [31:0] val, input int smp);
    check({tag, "_valid"}, 32'(out_valid_a),  32'd1);
    check({tag, "_idx"},   32'(class_idx_a),  32'(idx));
    check({tag, "_val"},   max_val_a,         val);
    check({tag, "_smp"},   32'(sample_idx_a), 32'(smp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int gap;
    rst     = 1'b0;
    start_a = 1'b0;
    ready_a = 1'b0;
    start_c = 1'b0;
    ready_c = 1'b0;
    model_reset(0);
    model_reset(1);
    rand_data();

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_a),       32'd0);
    check("rst_valid", 32'(out_valid_a),  32'd0);
    check("rst_done",  32'(done_a),       32'd0);
    check("rst_idx",   32'(class_idx_a),  32'd0);
    check("rst_val",   max_val_a,         32'd0);
    check("rst_smp",   32'(sample_idx_a), 32'd0);
    rst = 1'b1;

    // Basic argmax and tie handling, consumer always ready.
    set_row_a(0, 5, -3, 9, 2);
    set_row_a(1, 7, 7, 1, 7);
    ready_a = 1'b1;
    run_start_a(lat);
    check("t1_latency", 32'(lat), 32'(OS_A));
    expect_a("t1_s0", 2, 32'd9, 0);
    next_valid_a(gap);
    check("t1_gap", 32'(gap), 32'(OS_A));
    expect_a("t1_s1", 0, 32'd7, 1);
    @(negedge clk);
    check("t1_done", 32'(done_a), 32'd1);

    // Back-pressure: result must hold while out_ready is low.
    set_row_a(0, 1, 4, 2, 3);
    set_row_a(1, 9, 0, 0, 10);
    ready_a = 1'b0;
    run_start_a(lat);
    expect_a("t2_s0", 1, 32'd4, 0);
    repeat (3) begin
      @(negedge clk);
      expect_a("t2_hold", 1, 32'd4, 0);
    end
    ready_a = 1'b1;
    next_valid_a(gap);
    check("t2_gap", 32'(gap), 32'(OS_A));
    expect_a("t2_s1", 3, 32'd10, 1);
    check("t2_done_early", 32'(done_a), 32'd0);
    @(negedge clk);
    check("t2_done", 32'(done_a), 32'd1);

    // Signed compare; input changes and a repeated start mid-scan are ignored.
    set_row_a(0, -8, -2, -5, -100);
    set_row_a(1, -1, 5, 5, -7);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    set_row_a(0, 50, 60, 70, 80);
    set_row_a(1, 90, 10, 20, 30);
    start_a = 1'b1;
    @(negedge clk);
    check("t3_busy", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    gap = 2;
    while (!out_valid_a && gap < 50) begin
      @(negedge clk);
      gap++;
    end
    check("t3_latency", 32'(gap), 32'(OS_A));
    expect_a("t3_s0", 1, 32'hFFFF_FFFE, 0);
    next_valid_a(gap);
    expect_a("t3_s1", 1, 32'd5, 1);
    @(negedge clk);
    check("t3_done", 32'(done_a), 32'd1);

    // New start clears done; reset mid-scan aborts at once.
    rand_data();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("t4_done_clr", 32'(done_a), 32'd0);
    check("t4_busy",     32'(busy_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t4_rst_busy",  32'(busy_a),      32'd0);
    check("t4_rst_valid", 32'(out_valid_a), 32'd0);
    check("t4_rst_done",  32'(done_a),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("t4_quiet", 32'(out_valid_a), 32'd0);
    end

    // Single-score samples: results come back to back.
    data_c[0][0] = 32'd3;
    data_c[1][0] = 32'hFFFF_FFFF;
    data_c[2][0] = 32'd3;
    ready_c = 1'b1;
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int s = 0; s < CNT_C; s++) begin
      check("c_b2b_valid", 32'(out_valid_c),  32'd1);
      check("c_b2b_idx",   32'(class_idx_c),  32'd0);
      check("c_b2b_smp",   32'(sample_idx_c), 32'(s));
      check("c_b2b_val",   max_val_c,         data_c[s][0]);
      @(negedge clk);
    end
    check("c_b2b_done", 32'(done_c), 32'd1);

    // Randomised traffic on both instances, including occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start_a = ($urandom_range(0, 5) == 0);
      start_c = ($urandom_range(0, 5) == 0);
      ready_a = $urandom_range(0, 1) == 1;
      ready_c = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) rand_data();
      if ($urandom_range(0, 400) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    start_a = 1'b0;
    start_c = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
